// File: rtl/ccff_chain_loader_if.sv
// Bitstream word port into the configuration chain loader.
// The master drives word_data/word_valid; the loader answers with word_ready.
interface ccff_chain_loader_if #(
  parameter int WORD_W = 8
);
  logic [WORD_W-1:0] word_data;
  logic              word_valid;
  logic              word_ready;

  modport master (output word_data, output word_valid, input word_ready);
  modport slave  (input word_data, input word_valid, output word_ready);
endinterface

// File: rtl/ccff_chain_loader.sv
// Shifts a sync preamble then bitstream words MSB-first into a config chain and checks the preamble at the tail.
// Latency SYNC_W+CHAIN_LEN+#words cycles start->done; a word is taken only when the shift register is empty, and stalls hold ccff_head.
module ccff_chain_loader #(
  parameter int                CHAIN_LEN    = 64,
  parameter int                WORD_W       = 8,
  parameter int                SYNC_W       = 8,
  parameter logic [SYNC_W-1:0] SYNC_PATTERN = SYNC_W'(8'hA5)
) (
  input  logic               prog_clk,
  input  logic               pReset_n,
  input  logic               start,
  ccff_chain_loader_if.slave word_if,
  output logic               ccff_head,
  output logic               ccff_shift_en,
  input  logic               ccff_tail,
  output logic               busy,
  output logic               done,
  output logic               sync_err
);
  localparam int NWORDS    = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int LAST_BITS = ((CHAIN_LEN - 1) % WORD_W) + 1;
  localparam int TOTAL     = SYNC_W + CHAIN_LEN;
  localparam int CNT_W     = $clog2(TOTAL + 1);
  localparam int WC_W      = $clog2(NWORDS + 1);
  localparam int BL_W      = $clog2(WORD_W + 1);

  localparam logic [CNT_W-1:0] SYNC_C  = CNT_W'(SYNC_W);
  localparam logic [CNT_W-1:0] CHAIN_C = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] TOTAL_C = CNT_W'(TOTAL);
  localparam logic [WC_W-1:0]  LAST_WC = WC_W'(NWORDS - 1);
  localparam logic [BL_W-1:0]  LAST_BL = BL_W'(LAST_BITS - 1);
  localparam logic [BL_W-1:0]  FULL_BL = BL_W'(WORD_W - 1);

  typedef enum logic [1:0] {IDLE, SYNC, DATA, DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    shift_cnt_q, shift_cnt_d;
  logic [WC_W-1:0]     word_cnt_q, word_cnt_d;
  logic [WORD_W-1:0]   word_sr_q, word_sr_d;
  logic [BL_W-1:0]     bits_left_q, bits_left_d;
  logic [SYNC_W-1:0]   pre_sr_q, pre_sr_d;
  logic [SYNC_W-1:0]   chk_sr_q, chk_sr_d;
  logic                head_q, head_d;
  logic                shift_en_q, shift_en_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                accept;

  // In DATA a cleared shift_en means the word register has run dry.
  assign word_if.word_ready = (state_q == DATA) && !shift_en_q;
  assign accept             = word_if.word_ready && word_if.word_valid;

  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      state_q     <= IDLE;
      shift_cnt_q <= '0;
      word_cnt_q  <= '0;
      word_sr_q   <= '0;
      bits_left_q <= '0;
      pre_sr_q    <= '0;
      chk_sr_q    <= '0;
      head_q      <= 1'b0;
      shift_en_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_cnt_q <= shift_cnt_d;
      word_cnt_q  <= word_cnt_d;
      word_sr_q   <= word_sr_d;
      bits_left_q <= bits_left_d;
      pre_sr_q    <= pre_sr_d;
      chk_sr_q    <= chk_sr_d;
      head_q      <= head_d;
      shift_en_q  <= shift_en_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    shift_cnt_d = shift_cnt_q;
    word_cnt_d  = word_cnt_q;
    word_sr_d   = word_sr_q;
    bits_left_d = bits_left_q;
    pre_sr_d    = pre_sr_q;
    chk_sr_d    = chk_sr_q;
    head_d      = head_q;
    shift_en_d  = shift_en_q;
    done_d      = done_q;
    err_d       = err_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d     = SYNC;
          head_d      = SYNC_PATTERN[SYNC_W-1];
          shift_en_d  = 1'b1;
          pre_sr_d    = SYNC_PATTERN << 1;
          chk_sr_d    = SYNC_PATTERN;
          shift_cnt_d = '0;
          word_cnt_d  = '0;
          bits_left_d = '0;
          done_d      = 1'b0;
          err_d       = 1'b0;
        end
      end
      SYNC: begin
        shift_cnt_d = shift_cnt_q + 1'b1;
        if (shift_cnt_d == SYNC_C) begin
          state_d    = DATA;
          shift_en_d = 1'b0;
        end else begin
          head_d   = pre_sr_q[SYNC_W-1];
          pre_sr_d = pre_sr_q << 1;
        end
      end
      DATA: begin
        if (shift_en_q) begin
          shift_cnt_d = shift_cnt_q + 1'b1;
          if (shift_cnt_d == TOTAL_C) begin
            state_d    = DONE;
            shift_en_d = 1'b0;
            done_d     = 1'b1;
          end else if (bits_left_q != '0) begin
            head_d      = word_sr_q[WORD_W-1];
            word_sr_d   = word_sr_q << 1;
            bits_left_d = bits_left_q - 1'b1;
          end else begin
            shift_en_d = 1'b0;
          end
        end else if (accept) begin
          head_d      = word_if.word_data[WORD_W-1];
          word_sr_d   = word_if.word_data << 1;
          shift_en_d  = 1'b1;
          word_cnt_d  = word_cnt_q + 1'b1;
          // Low bits of the final word past the chain length are never shifted.
          bits_left_d = (word_cnt_q == LAST_WC) ? LAST_BL : FULL_BL;
        end
      end
      default: state_d = IDLE;
    endcase

    // The preamble reaches the tail once the chain is full; it may overlap SYNC on short chains.
    if (shift_en_q && (shift_cnt_q >= CHAIN_C)) begin
      if (ccff_tail != chk_sr_q[SYNC_W-1]) err_d = 1'b1;
      chk_sr_d = chk_sr_q << 1;
    end
  end

  assign ccff_head     = head_q;
  assign ccff_shift_en = shift_en_q;
  assign busy          = (state_q == SYNC) || (state_q == DATA);
  assign done          = done_q;
  assign sync_err      = err_q;
endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: a 20-flop chain instance (A5 preamble) and an 8-flop single-word instance.
// Expected head bits are queued as stimulus is driven and popped against the bits seen on shift cycles.
module tb_ccff_chain_loader;
  logic prog_clk = 1'b0;
  logic pReset_n;
  logic start_a, start_b;
  logic head_a, en_a, busy_a, done_a, err_a, tail_a;
  logic head_b, en_b, busy_b, done_b, err_b, tail_b;

  ccff_chain_loader_if #(.WORD_W(8)) a_if ();
  ccff_chain_loader_if #(.WORD_W(8)) b_if ();

  ccff_chain_loader #(.CHAIN_LEN(20), .WORD_W(8), .SYNC_W(8), .SYNC_PATTERN(8'hA5)) dut_a (
    .prog_clk(prog_clk), .pReset_n(pReset_n), .start(start_a), .word_if(a_if),
    .ccff_head(head_a), .ccff_shift_en(en_a), .ccff_tail(tail_a),
    .busy(busy_a), .done(done_a), .sync_err(err_a));

  ccff_chain_loader #(.CHAIN_LEN(8), .WORD_W(8), .SYNC_W(1), .SYNC_PATTERN(1'b1)) dut_b (
    .prog_clk(prog_clk), .pReset_n(pReset_n), .start(start_b), .word_if(b_if),
    .ccff_head(head_b), .ccff_shift_en(en_b), .ccff_tail(tail_b),
    .busy(busy_b), .done(done_b), .sync_err(err_b));

  always #5 prog_clk = ~prog_clk;

  // Chain models: plain shift registers clocked by the gated prog_clk.
  logic [19:0] chain_a = '0;
  logic [7:0]  chain_b = '0;
  int          tail_mode = 0;  // 0: 20 flops, 1: 19 flops, 2: tail stuck at 0
  always @(posedge prog_clk) if (en_a) chain_a <= {chain_a[18:0], head_a};
  always @(posedge prog_clk) if (en_b) chain_b <= {chain_b[6:0], head_b};
  assign tail_a = (tail_mode == 0) ? chain_a[19] : (tail_mode == 1) ? chain_a[18] : 1'b0;
  assign tail_b = chain_b[7];

  logic       exp_a[$], obs_a[$], exp_b[$], obs_b[$];
  int         acc_a, acc_b, stall_a, moved_a;
  logic       last_head_a = 1'b0;
  int         load_cycles_a, load_cycles_b;
  logic       done_after_start, busy_after_start;
  logic [7:0] words_a [3] = '{8'hF0, 8'h3C, 8'hB0};
  int         n_checks = 0, n_pass = 0;

  always @(negedge prog_clk) begin
    if (en_a) obs_a.push_back(head_a);
    if (busy_a && !en_a) begin
      stall_a++;
      if (head_a !== last_head_a) moved_a++;
    end
    if (a_if.word_ready && a_if.word_valid) acc_a++;
    last_head_a = head_a;
    if (en_b) obs_b.push_back(head_b);
    if (b_if.word_ready && b_if.word_valid) acc_b++;
  end

  task automatic drive_a(input int stall);
    logic [7:0] wd;
    int nb;
    for (int w = 0; w < 3; w++) begin
      if (w == 1 && stall > 0) begin
        a_if.word_valid = 1'b0;
        for (int i = 0; i < 100; i++) begin
          @(negedge prog_clk);
          if (a_if.word_ready) break;
        end
        repeat (stall) @(posedge prog_clk);
        #1;
      end
      wd = words_a[w];
      nb = (w == 2) ? 4 : 8;
      for (int b = 0; b < nb; b++) exp_a.push_back(wd[7-b]);
      a_if.word_data  = wd;
      a_if.word_valid = 1'b1;
      for (int i = 0; i < 100; i++) begin
        @(negedge prog_clk);
        if (a_if.word_ready) break;
      end
      @(posedge prog_clk);
      #1;
    end
    a_if.word_valid = 1'b0;
  endtask

  task automatic wait_done_a();
    load_cycles_a = -1;
    for (int c = 1; c <= 300; c++) begin
      @(posedge prog_clk);
      #1;
      if (done_a) begin
        load_cycles_a = c;
        break;
      end
    end
  endtask

  task automatic extra_start_a(input int start_at);
    if (start_at > 0) begin
      repeat (start_at - 1) @(posedge prog_clk);
      #1 start_a = 1'b1;
      @(posedge prog_clk);
      #1 start_a = 1'b0;
    end
  endtask

  task automatic run_load_a(input int stall, input int start_at);
    logic [7:0] p;
    p = 8'hA5;
    exp_a.delete(); obs_a.delete();
    acc_a = 0; stall_a = 0; moved_a = 0;
    @(posedge prog_clk);
    #1 start_a = 1'b1;
    for (int i = 7; i >= 0; i--) exp_a.push_back(p[i]);
    @(posedge prog_clk);
    #1 start_a = 1'b0;
    done_after_start = done_a;
    busy_after_start = busy_a;
    fork
      drive_a(stall);
      wait_done_a();
      extra_start_a(start_at);
    join
  endtask

  task automatic test_reset();
    n_checks++; if (head_a !== 1'b0) $display("FAIL reset_head got %b want 0", head_a); else n_pass++;
    n_checks++; if (en_a !== 1'b0) $display("FAIL reset_shift_en got %b want 0", en_a); else n_pass++;
    n_checks++; if (a_if.word_ready !== 1'b0) $display("FAIL reset_ready got %b want 0", a_if.word_ready); else n_pass++;
    n_checks++; if (busy_a !== 1'b0) $display("FAIL reset_busy got %b want 0", busy_a); else n_pass++;
    n_checks++; if (done_a !== 1'b0) $display("FAIL reset_done got %b want 0", done_a); else n_pass++;
    n_checks++; if (err_a !== 1'b0) $display("FAIL reset_sync_err got %b want 0", err_a); else n_pass++;
    n_checks++; if (en_b !== 1'b0 || busy_b !== 1'b0 || done_b !== 1'b0)
      $display("FAIL reset_b got en=%b busy=%b done=%b want 0", en_b, busy_b, done_b); else n_pass++;
  endtask

  task automatic test_basic();
    logic e, o;
    tail_mode = 0;
    run_load_a(0, 0);
    n_checks++; if (load_cycles_a !== 31) $display("FAIL basic_latency got %0d want 31", load_cycles_a); else n_pass++;
    n_checks++; if (acc_a !== 3) $display("FAIL basic_accepts got %0d want 3", acc_a); else n_pass++;
    n_checks++; if (stall_a !== 3) $display("FAIL basic_idle_cycles got %0d want 3", stall_a); else n_pass++;
    n_checks++; if (chain_a !== 20'hF03CB) $display("FAIL basic_chain got %h want f03cb", chain_a); else n_pass++;
    n_checks++; if (err_a !== 1'b0) $display("FAIL basic_sync_err got %b want 0", err_a); else n_pass++;
    n_checks++; if (busy_a !== 1'b0) $display("FAIL basic_busy got %b want 0", busy_a); else n_pass++;
    n_checks++; if (obs_a.size() !== exp_a.size())
      $display("FAIL basic_shift_count got %0d want %0d", obs_a.size(), exp_a.size()); else n_pass++;
    while (exp_a.size() > 0 && obs_a.size() > 0) begin
      e = exp_a.pop_front();
      o = obs_a.pop_front();
      n_checks++; if (o !== e) $display("FAIL basic_head_bit got %b want %b", o, e); else n_pass++;
    end
  endtask

  task automatic test_short_chain();
    tail_mode = 1;
    run_load_a(0, 0);
    n_checks++; if (err_a !== 1'b1) $display("FAIL short_sync_err got %b want 1", err_a); else n_pass++;
    n_checks++; if (done_a !== 1'b1) $display("FAIL short_done got %b want 1", done_a); else n_pass++;
    n_checks++; if (load_cycles_a !== 31) $display("FAIL short_latency got %0d want 31", load_cycles_a); else n_pass++;
    tail_mode = 0;
  endtask

  task automatic test_stall();
    logic e, o;
    tail_mode = 0;
    run_load_a(5, 0);
    n_checks++; if (load_cycles_a !== 36) $display("FAIL stall_latency got %0d want 36", load_cycles_a); else n_pass++;
    n_checks++; if (stall_a !== 8) $display("FAIL stall_idle_cycles got %0d want 8", stall_a); else n_pass++;
    n_checks++; if (moved_a !== 0) $display("FAIL stall_head_moved got %0d want 0", moved_a); else n_pass++;
    n_checks++; if (chain_a !== 20'hF03CB) $display("FAIL stall_chain got %h want f03cb", chain_a); else n_pass++;
    n_checks++; if (err_a !== 1'b0) $display("FAIL stall_sync_err got %b want 0", err_a); else n_pass++;
    n_checks++; if (obs_a.size() !== exp_a.size())
      $display("FAIL stall_shift_count got %0d want %0d", obs_a.size(), exp_a.size()); else n_pass++;
    while (exp_a.size() > 0 && obs_a.size() > 0) begin
      e = exp_a.pop_front();
      o = obs_a.pop_front();
      n_checks++; if (o !== e) $display("FAIL stall_head_bit got %b want %b", o, e); else n_pass++;
    end
  endtask

  task automatic test_reset_midload();
    tail_mode = 0;
    obs_a.delete();
    @(posedge prog_clk);
    #1 start_a = 1'b1;
    @(posedge prog_clk);
    #1 start_a = 1'b0;
    a_if.word_data  = 8'hF0;
    a_if.word_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge prog_clk);
      #2;
      if (obs_a.size() >= 12) break;
    end
    n_checks++; if (obs_a.size() !== 12) $display("FAIL midload_reach_n12 got %0d want 12", obs_a.size()); else n_pass++;
    pReset_n = 1'b0;
    #1;
    n_checks++; if (en_a !== 1'b0 || head_a !== 1'b0)
      $display("FAIL midload_reset_shift got en=%b head=%b want 0", en_a, head_a); else n_pass++;
    n_checks++; if (busy_a !== 1'b0 || done_a !== 1'b0 || err_a !== 1'b0 || a_if.word_ready !== 1'b0)
      $display("FAIL midload_reset_status got busy=%b done=%b err=%b rdy=%b want 0", busy_a, done_a, err_a, a_if.word_ready);
    else n_pass++;
    a_if.word_valid = 1'b0;
    @(negedge prog_clk);
    #2 pReset_n = 1'b1;
    run_load_a(0, 0);
    n_checks++; if (chain_a !== 20'hF03CB) $display("FAIL midload_reload_chain got %h want f03cb", chain_a); else n_pass++;
    n_checks++; if (err_a !== 1'b0) $display("FAIL midload_reload_sync_err got %b want 0", err_a); else n_pass++;
    n_checks++; if (load_cycles_a !== 31) $display("FAIL midload_reload_latency got %0d want 31", load_cycles_a); else n_pass++;
  endtask

  task automatic test_start_ignored();
    tail_mode = 0;
    run_load_a(0, 5);
    n_checks++; if (load_cycles_a !== 31) $display("FAIL busy_start_latency got %0d want 31", load_cycles_a); else n_pass++;
    n_checks++; if (acc_a !== 3) $display("FAIL busy_start_accepts got %0d want 3", acc_a); else n_pass++;
    n_checks++; if (chain_a !== 20'hF03CB) $display("FAIL busy_start_chain got %h want f03cb", chain_a); else n_pass++;
    n_checks++; if (done_a !== 1'b1) $display("FAIL pre_restart_done got %b want 1", done_a); else n_pass++;
    tail_mode = 2;
    run_load_a(0, 31);
    n_checks++; if (done_after_start !== 1'b0 || busy_after_start !== 1'b1)
      $display("FAIL restart_clears got done=%b busy=%b want done=0 busy=1", done_after_start, busy_after_start);
    else n_pass++;
    n_checks++; if (err_a !== 1'b1) $display("FAIL stuck_tail_sync_err got %b want 1", err_a); else n_pass++;
    n_checks++; if (load_cycles_a !== 31) $display("FAIL restart_latency got %0d want 31", load_cycles_a); else n_pass++;
    n_checks++; if (chain_a !== 20'hF03CB) $display("FAIL restart_chain got %h want f03cb", chain_a); else n_pass++;
    repeat (3) @(posedge prog_clk);
    #1;
    n_checks++; if (done_a !== 1'b1 || busy_a !== 1'b0 || en_a !== 1'b0)
      $display("FAIL start_at_done_edge got done=%b busy=%b en=%b want 1/0/0", done_a, busy_a, en_a); else n_pass++;
    tail_mode = 0;
  endtask

  task automatic test_single_word();
    logic [7:0] wd;
    logic e, o;
    wd = 8'h81;
    exp_b.delete(); obs_b.delete(); acc_b = 0;
    @(posedge prog_clk);
    #1 start_b = 1'b1;
    exp_b.push_back(1'b1);
    @(posedge prog_clk);
    #1 start_b = 1'b0;
    for (int b = 7; b >= 0; b--) exp_b.push_back(wd[b]);
    b_if.word_data  = wd;
    b_if.word_valid = 1'b1;
    load_cycles_b = -1;
    for (int c = 1; c <= 100; c++) begin
      @(posedge prog_clk);
      #1;
      if (done_b) begin
        load_cycles_b = c;
        break;
      end
    end
    b_if.word_valid = 1'b0;
    n_checks++; if (load_cycles_b !== 10) $display("FAIL single_latency got %0d want 10", load_cycles_b); else n_pass++;
    n_checks++; if (acc_b !== 1) $display("FAIL single_accepts got %0d want 1", acc_b); else n_pass++;
    n_checks++; if (chain_b !== 8'h81) $display("FAIL single_chain got %h want 81", chain_b); else n_pass++;
    n_checks++; if (err_b !== 1'b0) $display("FAIL single_sync_err got %b want 0", err_b); else n_pass++;
    n_checks++; if (obs_b.size() !== 9) $display("FAIL single_shift_count got %0d want 9", obs_b.size()); else n_pass++;
    while (exp_b.size() > 0 && obs_b.size() > 0) begin
      e = exp_b.pop_front();
      o = obs_b.pop_front();
      n_checks++; if (o !== e) $display("FAIL single_head_bit got %b want %b", o, e); else n_pass++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    pReset_n = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    a_if.word_data = '0;
    a_if.word_valid = 1'b0;
    b_if.word_data = '0;
    b_if.word_valid = 1'b0;
    repeat (3) @(posedge prog_clk);
    #1 pReset_n = 1'b1;
    @(posedge prog_clk);
    #1;
    test_reset();
    test_basic();
    test_short_chain();
    test_stall();
    test_reset_midload();
    test_start_ignored();
    test_single_word();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
